// File: rtl/io_echo_node_pkg.sv
// Shared channel widths, message bundle and FSM state type for io_echo_node.
package io_echo_node_pkg;

    localparam int NS_ADDRESS_SIZE = 6;
    localparam int NS_DATA_SIZE    = 8;
    localparam int NS_REDUN_SIZE   = 4;
    localparam int NS_ECHO_INC     = 1;

    localparam logic NS_ON  = 1'b1;
    localparam logic NS_OFF = 1'b0;

    localparam int ASZ = NS_ADDRESS_SIZE;
    localparam int DSZ = NS_DATA_SIZE;
    localparam int RSZ = NS_REDUN_SIZE;

    typedef logic [ASZ-1:0] addr_t;
    typedef logic [DSZ-1:0] dat_t;
    typedef logic [RSZ-1:0] red_t;

    typedef struct packed {
        addr_t src;
        addr_t dst;
        dat_t  dat;
        red_t  red;
    } msg_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_BUILD = 2'd2,
        ST_SEND  = 2'd3
    } state_e;

endpackage

// File: rtl/io_echo_node_if.sv
// Message channel: four payload fields plus a 4-phase req/ack pair.
interface io_echo_node_if;
    import io_echo_node_pkg::*;

    addr_t src;
    addr_t dst;
    dat_t  dat;
    red_t  red;
    logic  req;
    logic  ack;

    modport master (
        output src, dst, dat, red, req,
        input  ack
    );

    modport slave (
        input  src, dst, dat, red, req,
        output ack
    );

endinterface

// File: rtl/io_echo_node_redun.sv
// Redundancy field: bit i of {src,dst,dat} folds into red[i mod RSZ].
module io_echo_node_redun
    import io_echo_node_pkg::*;
(
    input  addr_t src,
    input  addr_t dst,
    input  dat_t  dat,
    output red_t  red
);

    localparam int W = 2 * ASZ + DSZ;

    logic [W-1:0] vec;

    assign vec = {src, dst, dat};

    always_comb begin
        red = '0;
        for (int i = 0; i < W; i++) begin
            red[i % RSZ] = red[i % RSZ] ^ vec[i];
        end
    end

endmodule

// File: rtl/io_echo_node.sv
// Responder node: verifies incoming messages, echoes those addressed here
// (data incremented) and relays the rest; status on the debug outputs.
module io_echo_node
    import io_echo_node_pkg::*;
#(
    parameter addr_t MY_ADDR = addr_t'(10),
    parameter dat_t  DAT_INC = dat_t'(NS_ECHO_INC)
) (
    input  logic             src0_clk,
    input  logic             reset,
    io_echo_node_if.slave    i0,
    io_echo_node_if.master   o0,
    output logic [3:0]       dbg_leds,
    output logic [3:0]       dbg_disp0,
    output logic [3:0]       dbg_disp1
);

    state_e     state_q, state_d;
    msg_t       in_q, in_d;
    msg_t       out_q, out_d;
    logic       req_q, req_d;
    logic       ack_q, ack_d;
    logic       err_q, err_d;
    logic [3:0] msg_cnt_q, msg_cnt_d;
    logic [3:0] err_cnt_q, err_cnt_d;
    red_t       in_red;
    red_t       out_red;

    io_echo_node_redun u_in_red (
        .src (in_q.src),
        .dst (in_q.dst),
        .dat (in_q.dat),
        .red (in_red)
    );

    io_echo_node_redun u_out_red (
        .src (out_q.src),
        .dst (out_q.dst),
        .dat (out_q.dat),
        .red (out_red)
    );

    always_ff @(posedge src0_clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            in_q      <= '0;
            out_q     <= '0;
            req_q     <= NS_OFF;
            ack_q     <= NS_OFF;
            err_q     <= NS_OFF;
            msg_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            in_q      <= in_d;
            out_q     <= out_d;
            req_q     <= req_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            msg_cnt_q <= msg_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_d      = in_q;
        out_d     = out_q;
        req_d     = req_q;
        ack_d     = ack_q;
        err_d     = err_q;
        msg_cnt_d = msg_cnt_q;
        err_cnt_d = err_cnt_q;

        // The input-side release runs regardless of where the FSM is.
        if (ack_q && !i0.req) begin
            ack_d = NS_OFF;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (i0.req && !ack_q) begin
                    in_d = '{src: i0.src, dst: i0.dst,
                             dat: i0.dat, red: i0.red};
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                ack_d = NS_ON;
                if (in_q.red != in_red) begin
                    err_d = NS_ON;
                    if (err_cnt_q != 4'hF) begin
                        err_cnt_d = err_cnt_q + 4'd1;
                    end
                    state_d = ST_IDLE;
                end else if (in_q.dst == MY_ADDR) begin
                    out_d.src = MY_ADDR;
                    out_d.dst = in_q.src;
                    out_d.dat = in_q.dat + DAT_INC;
                    state_d   = ST_BUILD;
                end else begin
                    out_d.src = in_q.src;
                    out_d.dst = in_q.dst;
                    out_d.dat = in_q.dat;
                    state_d   = ST_BUILD;
                end
            end
            ST_BUILD: begin
                out_d.red = out_red;
                // A previous transfer's ack must be gone before a new req.
                if (!o0.ack) begin
                    req_d   = NS_ON;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (o0.ack) begin
                    req_d     = NS_OFF;
                    msg_cnt_d = msg_cnt_q + 4'd1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign i0.ack = ack_q;
    assign o0.src = out_q.src;
    assign o0.dst = out_q.dst;
    assign o0.dat = out_q.dat;
    assign o0.red = out_q.red;
    assign o0.req = req_q;

    assign dbg_leds  = {ack_q, req_q, state_q != ST_IDLE, err_q};
    assign dbg_disp0 = msg_cnt_q;
    assign dbg_disp1 = err_cnt_q;

endmodule
